// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
// Holds the default geometry, the memOp width codes handed to the RF,
// and the grant encoding used by the round-robin arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned DW_DEF   = 32;

  typedef enum logic [1:0] {
    MEMOP_WORD = 2'b00,  // full word, also used for every ALU write
    MEMOP_LB   = 2'b01,
    MEMOP_LH   = 2'b10,
    MEMOP_LW   = 2'b11
  } memop_e;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard.
//   set_en/set_rd   : a load was issued to set_rd (rd 0 ignored)
//   clr_en/clr_rd   : a load return completed its handshake for clr_rd
//   rs/rt           : decode read addresses to check
//   wb_wr/wb_a3     : write currently sitting in the arbiter output stage
//   hazard_rs/rt    : read value not yet architecturally valid
//   pending         : one bit per register with a load outstanding
//   sb_err          : sticky protocol error (double issue / stray return)
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_rd,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_rd,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic            wb_wr,
  input  logic [AW-1:0]   wb_a3,
  output logic            hazard_rs,
  output logic            hazard_rt,
  output logic [NREG-1:0] pending,
  output logic            sb_err
);

  logic [NREG-1:0] pending_q, pending_d;
  logic            sb_err_q, sb_err_d;
  logic            set_vld, clr_vld;

  always_comb begin
    set_vld   = set_en & (set_rd != '0);
    clr_vld   = clr_en & (clr_rd != '0);
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    // Set is applied after clear so a re-issue to the same register wins.
    if (clr_vld) pending_d[clr_rd] = 1'b0;
    if (set_vld) pending_d[set_rd] = 1'b1;
    if (set_vld && pending_q[set_rd] && !(clr_vld && (clr_rd == set_rd)))
      sb_err_d = 1'b1;
    if (clr_vld && !pending_q[clr_rd])
      sb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  // A write in the output stage is not yet in the RF and there is no bypass.
  always_comb begin
    hazard_rs = (rs != '0) & (pending_q[rs] | (wb_wr & (wb_a3 == rs)));
    hazard_rt = (rt != '0) & (pending_q[rt] | (wb_wr & (wb_a3 == rt)));
  end

  assign pending = pending_q;
  assign sb_err  = sb_err_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter.
// Arbitrates ALU writeback and load return (valid/ready, round-robin on
// contention, ALU held off on WAW against an outstanding load), registers
// the winner into a one-cycle output stage driving RFWr/A3/WD/memOp, and
// tracks outstanding loads for decode read hazards.
//   alu_*      : ALU writeback request / grant
//   ld_*       : load return request / grant, ld_issue* marks new loads
//   rs/rt      : decode read addresses, hazard_rs/rt flags
//   rf_*       : registered RF write port
//   pending    : scoreboard vector, sb_err sticky protocol error
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_wd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [DW-1:0]   ld_wd,
  input  logic [1:0]      ld_memop,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_rd,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  output logic            hazard_rs,
  output logic            hazard_rt,
  output logic            rf_wr,
  output logic [AW-1:0]   rf_a3,
  output logic [DW-1:0]   rf_wd,
  output logic [1:0]      rf_memop,
  output logic [NREG-1:0] pending,
  output logic            sb_err
);

  gnt_e          last_grant_q, last_grant_d;
  logic          rf_wr_q, rf_wr_d;
  logic [AW-1:0] rf_a3_q, rf_a3_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  memop_e        rf_memop_q, rf_memop_d;
  logic          alu_elig, ld_elig, alu_gnt, ld_gnt;

  // Grants are gated by reset so every output reads 0 while held in reset.
  always_comb begin
    alu_elig = alu_valid & ((alu_rd == '0) | ~pending[alu_rd]);
    ld_elig  = ld_valid;
    alu_gnt  = 1'b0;
    ld_gnt   = 1'b0;
    if (rst) begin
      if (alu_elig && ld_elig) begin
        if (last_grant_q == GNT_LD) alu_gnt = 1'b1;
        else                        ld_gnt  = 1'b1;
      end else begin
        alu_gnt = alu_elig;
        ld_gnt  = ld_elig;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_wr_d      = 1'b0;
    rf_a3_d      = '0;
    rf_wd_d      = '0;
    rf_memop_d   = MEMOP_WORD;
    if (alu_gnt) begin
      last_grant_d = GNT_ALU;
      if (alu_rd != '0) begin
        rf_wr_d = 1'b1;
        rf_a3_d = alu_rd;
        rf_wd_d = alu_wd;
      end
    end else if (ld_gnt) begin
      last_grant_d = GNT_LD;
      if (ld_rd != '0) begin
        rf_wr_d    = 1'b1;
        rf_a3_d    = ld_rd;
        rf_wd_d    = ld_wd;
        rf_memop_d = memop_e'(ld_memop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GNT_LD;
      rf_wr_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      rf_memop_q   <= MEMOP_WORD;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wr_q      <= rf_wr_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd_q      <= rf_wd_d;
      rf_memop_q   <= rf_memop_d;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (ld_issue),
    .set_rd    (ld_issue_rd),
    .clr_en    (ld_gnt),
    .clr_rd    (ld_rd),
    .rs        (rs),
    .rt        (rt),
    .wb_wr     (rf_wr_q),
    .wb_a3     (rf_a3_q),
    .hazard_rs (hazard_rs),
    .hazard_rt (hazard_rt),
    .pending   (pending),
    .sb_err    (sb_err)
  );

  assign alu_ready = alu_gnt;
  assign ld_ready  = ld_gnt;
  assign rf_wr     = rf_wr_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd     = rf_wd_q;
  assign rf_memop  = rf_memop_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_wd;
  logic [1:0]  ld_memop;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  rs, rt;
  logic        hazard_rs, hazard_rt;
  logic        rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [1:0]  rf_memop;
  logic [31:0] pending;
  logic        sb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
    .ld_memop(ld_memop), .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rs(rs), .rt(rt), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_memop(rf_memop),
    .pending(pending), .sb_err(sb_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_wd = 0;
    ld_valid = 0; ld_rd = 0; ld_wd = 0; ld_memop = 0;
    ld_issue = 0; ld_issue_rd = 0; rs = 0; rt = 0;
  endtask

  task automatic do_reset();
    rst = 0; idle();
    step(); step();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; idle();
    step(); step();
    checks++; if ({rf_wr, rf_a3, rf_wd, rf_memop} !== 40'd0) begin failures++;
      $display("FAIL reset_rf got=%0h exp=0", {rf_wr, rf_a3, rf_wd, rf_memop}); end
    checks++; if ({pending, sb_err} !== 33'd0) begin failures++;
      $display("FAIL reset_sb got=%0h exp=0", {pending, sb_err}); end
    alu_valid = 1; alu_rd = 5; ld_valid = 1; ld_rd = 6; #1;
    checks++; if ({alu_ready, ld_ready, hazard_rs, hazard_rt} !== 4'b0) begin failures++;
      $display("FAIL reset_ready got=%b exp=0000", {alu_ready, ld_ready, hazard_rs, hazard_rt}); end
    idle();
    rst = 1;
    step();
    checks++; if (rf_wr !== 1'b0) begin failures++;
      $display("FAIL idle_rf_wr got=%b exp=0", rf_wr); end
  endtask

  task automatic test_alu_basic();
    alu_valid = 1; alu_rd = 5; alu_wd = 32'h12345678; #1;
    checks++; if (alu_ready !== 1'b1) begin failures++;
      $display("FAIL alu_ready got=%b exp=1", alu_ready); end
    step(); idle();
    checks++; if ({rf_wr, rf_a3, rf_wd, rf_memop} !== {1'b1, 5'd5, 32'h12345678, 2'b00}) begin failures++;
      $display("FAIL alu_write got=%0h exp=%0h", {rf_wr, rf_a3, rf_wd, rf_memop}, {1'b1, 5'd5, 32'h12345678, 2'b00}); end
    step();
    checks++; if (rf_wr !== 1'b0) begin failures++;
      $display("FAIL alu_one_cycle got=%b exp=0", rf_wr); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_memop;
    logic [4:0] exp_a3;
    logic       exp_alu;
    do_reset();
    alu_valid = 1; alu_rd = 3; alu_wd = 32'h33;
    ld_valid = 1; ld_rd = 4; ld_wd = 32'h44; ld_memop = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      exp_a3 = exp_alu ? 5'd3 : 5'd4;
      exp_memop = exp_alu ? 2'b00 : 2'b11;
      #1;
      checks++; if ({alu_ready, ld_ready} !== {exp_alu, ~exp_alu}) begin failures++;
        $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {alu_ready, ld_ready}, {exp_alu, ~exp_alu}); end
      step();
      checks++; if ({rf_wr, rf_a3, rf_memop} !== {1'b1, exp_a3, exp_memop}) begin failures++;
        $display("FAIL rr_write[%0d] got=%0h exp=%0h", i, {rf_wr, rf_a3, rf_memop}, {1'b1, exp_a3, exp_memop}); end
    end
    idle();
    // Load returns to a never-issued register are protocol errors.
    checks++; if (sb_err !== 1'b1) begin failures++;
      $display("FAIL rr_stray_err got=%b exp=1", sb_err); end
  endtask

  task automatic test_hazard();
    do_reset();
    ld_issue = 1; ld_issue_rd = 7;
    step();
    ld_issue = 0; rs = 7; #1;
    checks++; if ({hazard_rs, pending} !== {1'b1, 32'h0000_0080}) begin failures++;
      $display("FAIL hz_set got=%0h exp=%0h", {hazard_rs, pending}, {1'b1, 32'h0000_0080}); end
    alu_valid = 1; alu_rd = 7; alu_wd = 32'hAA; #1;
    checks++; if (alu_ready !== 1'b0) begin failures++;
      $display("FAIL hz_waw_hold got=%b exp=0", alu_ready); end
    step();
    checks++; if ({alu_ready, rf_wr} !== 2'b00) begin failures++;
      $display("FAIL hz_waw_hold2 got=%b exp=00", {alu_ready, rf_wr}); end
    alu_valid = 0;
    ld_valid = 1; ld_rd = 7; ld_memop = 2'b01; ld_wd = 32'h80; #1;
    checks++; if (ld_ready !== 1'b1) begin failures++;
      $display("FAIL hz_ld_ready got=%b exp=1", ld_ready); end
    step();
    ld_valid = 0;
    checks++; if ({rf_wr, rf_a3, rf_wd, rf_memop} !== {1'b1, 5'd7, 32'h80, 2'b01}) begin failures++;
      $display("FAIL hz_ld_write got=%0h exp=%0h", {rf_wr, rf_a3, rf_wd, rf_memop}, {1'b1, 5'd7, 32'h80, 2'b01}); end
    checks++; if ({hazard_rs, pending} !== {1'b1, 32'h0}) begin failures++;
      $display("FAIL hz_outstage got=%0h exp=%0h", {hazard_rs, pending}, {1'b1, 32'h0}); end
    step();
    checks++; if ({hazard_rs, rf_wr} !== 2'b00) begin failures++;
      $display("FAIL hz_clear got=%b exp=00", {hazard_rs, rf_wr}); end
    alu_valid = 1; alu_rd = 7; alu_wd = 32'hAA; #1;
    checks++; if (alu_ready !== 1'b1) begin failures++;
      $display("FAIL hz_alu_release got=%b exp=1", alu_ready); end
    step(); idle();
    checks++; if ({rf_wr, rf_a3, rf_wd, rf_memop, sb_err} !== {1'b1, 5'd7, 32'hAA, 2'b00, 1'b0}) begin failures++;
      $display("FAIL hz_alu_write got=%0h exp=%0h", {rf_wr, rf_a3, rf_wd, rf_memop, sb_err}, {1'b1, 5'd7, 32'hAA, 2'b00, 1'b0}); end
  endtask

  task automatic test_set_clear();
    do_reset();
    ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_valid = 1; ld_rd = 9; ld_wd = 32'h99; #1;
    checks++; if (ld_ready !== 1'b1) begin failures++;
      $display("FAIL sc_ld_ready got=%b exp=1", ld_ready); end
    step();
    ld_valid = 0; ld_issue = 0;
    checks++; if ({pending, sb_err} !== {32'h0000_0200, 1'b0}) begin failures++;
      $display("FAIL sc_set_wins got=%0h exp=%0h", {pending, sb_err}, {32'h0000_0200, 1'b0}); end
    ld_issue = 1;
    step();
    ld_issue = 0;
    checks++; if ({pending, sb_err} !== {32'h0000_0200, 1'b1}) begin failures++;
      $display("FAIL sc_double_issue got=%0h exp=%0h", {pending, sb_err}, {32'h0000_0200, 1'b1}); end
    step(); step();
    checks++; if (sb_err !== 1'b1) begin failures++;
      $display("FAIL sc_sticky got=%b exp=1", sb_err); end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1; alu_rd = 0; alu_wd = 32'hFFFF_FFFF; #1;
    checks++; if (alu_ready !== 1'b1) begin failures++;
      $display("FAIL z_alu_ready got=%b exp=1", alu_ready); end
    step(); idle();
    checks++; if (rf_wr !== 1'b0) begin failures++;
      $display("FAIL z_no_write got=%b exp=0", rf_wr); end
    ld_issue = 1; ld_issue_rd = 0;
    step();
    ld_issue = 0; rs = 0; rt = 9; #1;
    checks++; if (pending !== 32'h0000_0200) begin failures++;
      $display("FAIL z_pending got=%0h exp=200", pending); end
    checks++; if ({hazard_rs, hazard_rt} !== 2'b01) begin failures++;
      $display("FAIL z_hazard got=%b exp=01", {hazard_rs, hazard_rt}); end
    idle();
  endtask

  task automatic test_reset_mid();
    ld_issue = 1; ld_issue_rd = 2;
    step();
    ld_issue = 0;
    ld_valid = 1; ld_rd = 2; ld_memop = 2'b10; ld_wd = 32'h1234; #1;
    checks++; if (ld_ready !== 1'b1) begin failures++;
      $display("FAIL rm_ld_ready got=%b exp=1", ld_ready); end
    step();
    ld_valid = 0;
    checks++; if ({rf_wr, rf_a3} !== {1'b1, 5'd2}) begin failures++;
      $display("FAIL rm_inflight got=%0h exp=%0h", {rf_wr, rf_a3}, {1'b1, 5'd2}); end
    rst = 0; #1;
    checks++; if ({rf_wr, pending, sb_err} !== 34'd0) begin failures++;
      $display("FAIL rm_dropped got=%0h exp=0", {rf_wr, pending, sb_err}); end
    #2 rst = 1;
    alu_valid = 1; alu_rd = 3; alu_wd = 32'h3;
    ld_valid = 1; ld_rd = 4; ld_wd = 32'h4; #1;
    checks++; if ({alu_ready, ld_ready} !== 2'b10) begin failures++;
      $display("FAIL rm_first_alu got=%b exp=10", {alu_ready, ld_ready}); end
    step(); idle();
    checks++; if ({rf_wr, rf_a3} !== {1'b1, 5'd3}) begin failures++;
      $display("FAIL rm_alu_write got=%0h exp=%0h", {rf_wr, rf_a3}, {1'b1, 5'd3}); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_alu_basic();
    test_round_robin();
    test_hazard();
    test_set_clear();
    test_rd_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register-file write port (RFWr/A3/WD/memOp) between the ALU writeback path and the multi-cycle load-return path. It arbitrates with valid/ready handshakes and registers the winning write into a one-cycle output stage. It also keeps a per-register pending-load scoreboard that raises read hazards for the rs/rt decode addresses.

Parameters:
NREG, 32, number of architectural registers (register 0 is hardwired zero)
AW, 5, register address width
DW, 32, write data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_rd  in  AW  ALU destination register
alu_wd  in  DW  ALU result
ld_valid  in  1  load-return request
ld_ready  out  1  load request granted this cycle
ld_rd  in  AW  load destination register
ld_wd  in  DW  raw load data
ld_memop  in  2  load width code, passed through to RF memOp
ld_issue  in  1  a load was issued this cycle
ld_issue_rd  in  AW  destination of the issued load
rs  in  AW  decode read address 1
rt  in  AW  decode read address 2
hazard_rs  out  1  rs value not yet architecturally valid
hazard_rt  out  1  rt value not yet architecturally valid
rf_wr  out  1  RF write enable (to RFWr)
rf_a3  out  AW  RF write address
rf_wd  out  DW  RF write data
rf_memop  out  2  RF write memOp
pending  out  NREG  scoreboard bit vector
sb_err  out  1  sticky scoreboard protocol error

Behaviour:
- Reset (rst=0, async): rf_wr=0, rf_a3=0, rf_wd=0, rf_memop=0, pending=0, sb_err=0, last_grant=LD. All outputs drive 0 during reset.
- Eligibility: alu_elig = alu_valid & (alu_rd==0 | !pending[alu_rd]). The ALU is held off on WAW against an outstanding load. ld_elig = ld_valid.
- Arbitration is combinational within the cycle, and at most one grant is issued per cycle.
  - Only one request eligible: that request is granted.
  - Both eligible: the requester that was not last_grant wins (round-robin).
  - After reset the ALU wins the first contention.
  - last_grant updates only on a grant.
- alu_ready = ALU granted; ld_ready = LD granted. A handshake is valid & ready in the same cycle. The requester must hold rd/wd/memop stable while valid & !ready.
- Output stage: a grant in cycle N produces rf_wr/rf_a3/rf_wd/rf_memop in cycle N+1 for exactly one cycle. With no grant in N, rf_wr=0 in N+1. The RF never back-pressures.
- ALU writes drive rf_memop=2'b00. LD writes pass ld_memop and ld_wd unmodified, because sign extension happens in the RF.
- rd==0: the handshake completes normally, rf_wr stays 0 in N+1, and the scoreboard is unchanged.
- Scoreboard set: ld_issue & ld_issue_rd!=0 sets pending[ld_issue_rd] at the next edge.
- Scoreboard clear: an LD handshake clears pending[ld_rd] at the next edge.
- Same register set and cleared in the same cycle: set wins, because a new load is outstanding.
- sb_err is sticky until reset. It sets on:
  - ld_issue to a register that is already pending and not being cleared this cycle;
  - an LD handshake with ld_rd!=0 whose register is not pending.
- Hazards: hazard_rs = rs!=0 & (pending[rs] | (rf_wr & rf_a3==rs)). hazard_rt is the same with rt. Both are combinational, and there is no bypass in this block.
- Reset mid-operation: the in-flight output-stage write is dropped (rf_wr forced 0) and all pending bits are lost.

Decomposition:
- Shared package:
  - MEMOP codes: 00 word/ALU, 01 lb, 10 lh, 11 lw.
  - Grant encoding: GNT_ALU=0, GNT_LD=1.
  - AW/DW/NREG defaults.
- One sub-module, rf_scoreboard: holds the pending vector, set/clear priority, sb_err, and the hazard lookup.
- Arbitration and the output stage stay in the top.

Test Plan:
1. Reset release, idle inputs -> all outputs 0. Then alu_valid, alu_rd=5, alu_wd=0x12345678 -> alu_ready=1 that cycle; next cycle rf_wr=1, rf_a3=5, rf_wd=0x12345678, rf_memop=00.
2. alu_valid and ld_valid held for 4 cycles (rd 3 and 4, no pending) -> grants ALU, LD, ALU, LD; rf_a3 sequence 3,4,3,4, one cycle after each grant.
3. ld_issue rd=7, then rs=7 -> hazard_rs=1. alu_valid rd=7 -> alu_ready=0 while pending. LD handshake rd=7, ld_memop=01, ld_wd=0x80 -> next cycle rf_wr=1, rf_memop=01, hazard_rs still 1 from the output stage. Following cycle hazard_rs=0, then alu_ready=1.
4. ld_issue rd=9 in the same cycle as an LD handshake rd=9 (pending) -> pending[9] remains 1, sb_err stays 0. A second ld_issue rd=9 with no clear -> sb_err=1 and stays set.
5. alu_valid rd=0, wd=0xFFFFFFFF -> alu_ready=1, rf_wr=0 next cycle. ld_issue rd=0 -> pending unchanged, hazard_rs with rs=0 is 0.
6. LD handshake rd=2 granted, rst pulsed low before the next edge -> rf_wr=0 immediately, pending=0, sb_err=0, next contention grants ALU first.
